// File: rtl/enc_frame_rx_pkg.sv
// enc_frame_rx_pkg: shared constants, FSM state types and baud helper.
// CHECK frame state exists only when ENC_FRAME_RX_CHECKSUM_EN is defined.
package enc_frame_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } byte_state_t;

`ifdef ENC_FRAME_RX_CHECKSUM_EN
  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } frame_state_t;
`else
  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD
  } frame_state_t;
`endif

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop sync, bit timer and 8N1 byte FSM (LSB first).
// Ports: clk, rst_n, rx -> data[7:0], data_valid pulse, frame_error pulse.
module uart_rx_byte
  import enc_frame_rx_pkg::*;
#(
  parameter int CLK_HZ = 16000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error
);

  localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] CNT_BIT = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(HALF - 1);

  logic              s0;
  logic              s1;
  logic              s_prev;
  logic              wait_high;
  byte_state_t       st;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        sh;
  logic              fall;

  assign fall = s_prev & ~s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      s_prev      <= 1'b1;
      wait_high   <= 1'b0;
      st          <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      s0          <= rx;
      s1          <= s0;
      s_prev      <= s1;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      unique case (st)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          // After a framing error the line must return high
          // before another falling edge can start a byte.
          if (wait_high) begin
            if (s1)
              wait_high <= 1'b0;
          end else if (fall) begin
            st <= START;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            st  <= s1 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt     <= '0;
            sh      <= {s1, sh[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7)
              st <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_BIT) begin
            cnt <= '0;
            st  <= IDLE;
            if (s1) begin
              data       <= sh;
              data_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
              wait_high   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/enc_frame_rx.sv
// enc_frame_rx: receives A5-synced frames of NUM_MOTORS encoder counts.
// Ports: CLK, RST_N, rx -> counts, frame_valid, frame_err, busy. Macro: ENC_FRAME_RX_CHECKSUM_EN.
module enc_frame_rx
  import enc_frame_rx_pkg::*;
#(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int NUM_MOTORS = 12,
  parameter int CNT_W      = 5
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        rx,
  output logic [NUM_MOTORS*CNT_W-1:0] counts,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int IDX_W =
    (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOTORS - 1);
  localparam logic [7:0] RANGE_MASK = 8'(8'hFF << CNT_W);

  logic [7:0]                  rx_data;
  logic                        rx_dv;
  logic                        rx_fe;
  frame_state_t                st;
  logic [IDX_W-1:0]            idx;
  logic [CNT_W-1:0]            shadow [NUM_MOTORS];
  logic [NUM_MOTORS*CNT_W-1:0] frame_next;
  logic                        range_bad;
`ifdef ENC_FRAME_RX_CHECKSUM_EN
  logic [7:0]                  csum;
`endif

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_byte (
    .clk         (CLK),
    .rst_n       (RST_N),
    .rx          (rx),
    .data        (rx_data),
    .data_valid  (rx_dv),
    .frame_error (rx_fe)
  );

  assign range_bad = |(rx_data & RANGE_MASK);

  // Without a checksum the last slot is taken straight from the
  // incoming byte so the copy lands the cycle after its stop sample.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < NUM_MOTORS; k++)
      frame_next[k*CNT_W +: CNT_W] = shadow[k];
`ifndef ENC_FRAME_RX_CHECKSUM_EN
    frame_next[(NUM_MOTORS-1)*CNT_W +: CNT_W] = rx_data[CNT_W-1:0];
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st          <= HUNT;
      idx         <= '0;
      counts      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      for (int k = 0; k < NUM_MOTORS; k++)
        shadow[k] <= '0;
`ifdef ENC_FRAME_RX_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      unique case (st)
        HUNT: begin
          if (rx_dv && rx_data == SYNC_BYTE) begin
            st   <= PAYLOAD;
            idx  <= '0;
            busy <= 1'b1;
`ifdef ENC_FRAME_RX_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        PAYLOAD: begin
          if (rx_fe || (rx_dv && range_bad)) begin
            frame_err <= 1'b1;
            st        <= HUNT;
            busy      <= 1'b0;
          end else if (rx_dv) begin
            shadow[idx] <= rx_data[CNT_W-1:0];
            idx         <= idx + 1'b1;
`ifdef ENC_FRAME_RX_CHECKSUM_EN
            csum        <= csum ^ rx_data;
            if (idx == LAST)
              st <= CHECK;
`else
            if (idx == LAST) begin
              counts      <= frame_next;
              frame_valid <= 1'b1;
              st          <= HUNT;
              busy        <= 1'b0;
            end
`endif
          end
        end
`ifdef ENC_FRAME_RX_CHECKSUM_EN
        CHECK: begin
          if (rx_fe || (rx_dv && rx_data != csum)) begin
            frame_err <= 1'b1;
            st        <= HUNT;
            busy      <= 1'b0;
          end else if (rx_dv) begin
            counts      <= frame_next;
            frame_valid <= 1'b1;
            st          <= HUNT;
            busy        <= 1'b0;
          end
        end
`endif
        default: begin
          st   <= HUNT;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_frame_rx.sv
// tb_enc_frame_rx: directed frames with a scoreboard of expected
// frame_valid / frame_err events checked by a separate monitor.
module tb_enc_frame_rx;

  localparam int CLK_HZ = 3686400;
  localparam int BAUD   = 115200;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int N      = 12;
  localparam int W      = 5;

  typedef struct {
    bit             is_err;
    logic [N*W-1:0] cnt;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rx;
  logic [N*W-1:0] counts;
  logic           frame_valid;
  logic           frame_err;
  logic           busy;

  exp_t           q[$];
  logic [N*W-1:0] model;
  logic [7:0]     pay [N];
  int             checks = 0;
  int             errors = 0;

  enc_frame_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .NUM_MOTORS (N),
    .CNT_W      (W)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .rx          (rx),
    .counts      (counts),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (frame_valid || frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got valid=%b err=%b expected none",
                 frame_valid, frame_err);
      end else begin
        e = q.pop_front();
        check("event_kind", {62'd0, frame_err, frame_valid},
              e.is_err ? 64'd2 : 64'd1);
        check("event_counts", counts, e.cnt);
      end
    end
  end

  function automatic logic [N*W-1:0] pack_pay();
    logic [N*W-1:0] v = '0;
    for (int k = 0; k < N; k++)
      v[k*W +: W] = pay[k][W-1:0];
    return v;
  endfunction

  task automatic push_valid();
    model = pack_pay();
    q.push_back('{1'b0, model});
  endtask

  task automatic push_err();
    q.push_back('{1'b1, model});
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_hi);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_hi;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit good, input bit chk_zero);
    logic [7:0] x = 8'h00;
    if (good) push_valid();
    else push_err();
    send_byte(8'hA5, 1'b1);
    check("busy_after_sync", {63'd0, busy}, 64'd1);
    for (int k = 0; k < N; k++) begin
      if (chk_zero && k == N - 1)
        check("counts_hold_zero", counts, 64'd0);
      send_byte(pay[k], 1'b1);
      x = x ^ pay[k];
    end
`ifdef ENC_FRAME_RX_CHECKSUM_EN
    send_byte(good ? x : (x ^ 8'h01), 1'b1);
`endif
    idle(2);
    check("busy_after_frame", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    model = '0;
    repeat (5) @(negedge clk);
    check("reset_counts", counts, 64'd0);
    check("reset_flags", {61'd0, frame_valid, frame_err, busy}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Counts k = k.
    for (int k = 0; k < N; k++) pay[k] = 8'(k);
    send_frame(1'b1, 1'b0);
    check("frame_a_counts", counts, 64'(model));

    // Out-of-range byte 5 aborts the frame.
    for (int k = 0; k < N; k++) pay[k] = 8'(31 - k);
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(pay[k], 1'b1);
    push_err();
    send_byte(8'h20, 1'b1);
    repeat (2) @(negedge clk);
    check("range_busy_drop", {63'd0, busy}, 64'd0);
    check("range_counts", counts, 64'(model));
    idle(2);

    // Stop bit low on payload byte 3, then a long break.
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 3; k++) send_byte(pay[k], 1'b1);
    push_err();
    send_byte(pay[3], 1'b0);
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    idle(2);
    check("break_busy", {63'd0, busy}, 64'd0);
    check("break_counts", counts, 64'(model));
    send_frame(1'b1, 1'b0);

    // Glitch just under half a bit, then a non-sync byte.
    rx = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    idle(2);
    check("glitch_busy", {63'd0, busy}, 64'd0);
    send_byte(8'h37, 1'b1);
    check("hunt_ignores", {63'd0, busy}, 64'd0);
    for (int k = 0; k < N; k++) pay[k] = 8'(k + 10);
    send_frame(1'b1, 1'b0);

    // Reset mid-frame.
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 6; k++) send_byte(8'h11, 1'b1);
    rst_n = 1'b0;
    model = '0;
    repeat (4) @(negedge clk);
    check("midreset_counts", counts, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    idle(2);
    for (int k = 0; k < N; k++) pay[k] = 8'(31 - 2 * k);
    send_frame(1'b1, 1'b1);
    check("post_reset_counts", counts, 64'(model));

`ifdef ENC_FRAME_RX_CHECKSUM_EN
    for (int k = 0; k < N; k++) pay[k] = 8'h01;
    send_frame(1'b1, 1'b0);
    for (int k = 0; k < N; k++) pay[k] = 8'h01;
    send_frame(1'b0, 1'b0);
    check("bad_csum_counts", counts, 64'(model));
`endif

    idle(4);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got none expected err=%b", e.is_err);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_frame_rx.md
ENC_FRAME_RX -- requirements
Module: enc_frame_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter NUM_MOTORS, default 12, encoder counts per frame.
REQ-004 SHALL have parameter CNT_W, default 5, width of each encoder count (1..8).
REQ-005 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 SHALL have port counts  output  NUM_MOTORS*CNT_W  last accepted counts; motor k at bits [k*CNT_W +: CNT_W].
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when counts updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-011 SHALL have port busy  output  1  high from sync byte accepted until frame accepted or discarded.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer before any use.
REQ-013 SHALL use bit period CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 138 at defaults) and sample at CLKS_PER_BIT/2 into each bit.
REQ-014 Byte FSM SHALL use states IDLE, START, DATA, STOP: IDLE->START on synchronized falling edge; START->IDLE silently if line high at mid-start; START->DATA otherwise; DATA->STOP after 8 samples; STOP->IDLE after stop sample.
REQ-015 Stop sample low SHALL be a framing error; byte FSM SHALL then wait for line high before accepting a new start edge (break does not retrigger).
REQ-016 Frame FSM SHALL use states HUNT, PAYLOAD, CHECK: HUNT->PAYLOAD on byte 0xA5; non-0xA5 bytes in HUNT ignored without error.
REQ-017 In PAYLOAD, byte i (0..NUM_MOTORS-1) SHALL be written to shadow slot i; 0xA5 in PAYLOAD is data, not resync.
REQ-018 Payload byte with any bit >= CNT_W set SHALL discard the frame.
REQ-019 Accepted frame SHALL copy all shadow slots to counts in one cycle, with frame_valid pulsed the same cycle; counts never shows a partial frame.
REQ-020 Acceptance SHALL occur one cycle after the final byte's stop sample.
REQ-021 Discard (framing error in PAYLOAD/CHECK, range error, checksum mismatch) SHALL pulse frame_err, leave counts unchanged, return to HUNT.
REQ-022 Framing error in HUNT SHALL not pulse frame_err.
REQ-023 busy SHALL be high in PAYLOAD and CHECK only.

Reset
REQ-024 RST_N low SHALL asynchronously clear counts, shadow slots, frame_valid, frame_err, busy, all counters; both FSMs to IDLE/HUNT; synchronizer flops to 1.
REQ-025 Reset mid-frame SHALL drop the partial frame with no frame_err; first frame after release requires a fresh 0xA5.

Configuration
REQ-026 With ENC_FRAME_RX_CHECKSUM_EN defined, PAYLOAD->CHECK after last payload byte; next byte SHALL equal XOR of all payload bytes, else discard; acceptance one cycle after checksum stop sample.
REQ-027 Without ENC_FRAME_RX_CHECKSUM_EN, PAYLOAD SHALL accept directly after last payload byte; CHECK state absent.

Structure
REQ-028 Package enc_frame_rx_pkg SHALL hold SYNC_BYTE (8'hA5), byte- and frame-FSM state typedefs, and the CLKS_PER_BIT constant function.
REQ-029 Byte reception (synchronizer, bit timer, byte FSM) SHALL be sub-module uart_rx_byte, outputs data[7:0], data_valid pulse, frame_error pulse.

Verification
REQ-030 Defaults, no checksum: A5, 00..0B at 115200 -> one frame_valid, counts slot k = k, no frame_err.
REQ-031 Checksum on: A5, 12 bytes 0x01, checksum 0x00 -> frame_valid; same frame with checksum 0x01 -> frame_err, counts unchanged.
REQ-032 Payload byte 5 = 0x20 -> frame_err at end of that byte, busy drops, counts unchanged.
REQ-033 Stop bit forced low on payload byte 3, then line low 3 byte times, then valid frame -> one frame_err, no spurious bytes, then frame_valid.
REQ-034 0.5-bit low glitch on idle line, then 0x37 0xA5 and 12 payload bytes -> glitch and 0x37 ignored, frame accepted.
REQ-035 RST_N low after 6 payload bytes, released, full frame sent -> counts zero until new frame_valid, no frame_err.
